apb_mem_responder: RTL and testbench
====================================

Name: apb_mem_responder

Overview:
- APB completer (slave) holding a small word-addressed data memory; serves the APB initiator blocks in the design.
- Supports reads, writes, programmable wait states and PSLVERR reporting.
- Provides a read-only transfer-count register.
- A side load port lets the system pre-fill memory contents outside of APB traffic.

Parameters:
- DEPTH, 16: number of 32-bit words; valid word addresses are 0..DEPTH-1 (DEPTH <= 255).
- WAIT_CYCLES, 1: access-phase cycles with pready_o low before completion (0..15).

Ports:
- pclk_i  input  1  APB clock; all logic on the rising edge.
- presetn_i  input  1  reset. Asynchronous assert, active-low; release is synchronous to pclk_i.
- psel_i  input  1  APB select.
- penable_i  input  1  APB enable (access phase).
- paddr_i  input  8  word address (one address step = one 32-bit word).
- pwrite_i  input  1  1 = write, 0 = read.
- pwdata_i  input  32  write data.
- prdata_o  output  32  read data; valid only while pready_o=1.
- pready_o  output  1  transfer completion.
- pslverr_o  output  1  error flag; valid only while pready_o=1.
- ld_en_i  input  1  side-load write strobe.
- ld_addr_i  input  8  side-load word address.
- ld_data_i  input  32  side-load data.
- xfer_cnt_o  output  16  count of completed APB transfers, including errored ones.

Behaviour:
- Reset (presetn_i=0, asynchronous, valid mid-transfer):
  - state=IDLE; all memory words=0; xfer_cnt_o=0; wait counter=0.
  - pready_o=0, pslverr_o=0, prdata_o=0 immediately.
  - Any in-flight transfer is dropped; no write commits.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel_i=1 && penable_i=0 (setup phase). Latch paddr_i, pwrite_i and pwdata_i; load wait_cnt=WAIT_CYCLES.
  - In ACCESS with psel_i=1 && penable_i=1 and wait_cnt!=0: pready_o=0; decrement wait_cnt.
  - In ACCESS with psel_i=1 && penable_i=1 and wait_cnt==0: pready_o=1 combinationally in that cycle; transfer completes at the clock edge; next state IDLE.
  - In ACCESS with psel_i=0 (aborted transfer): -> IDLE; no write; no count.
  - In ACCESS with psel_i=1 && penable_i=0: treat as a new setup. Re-latch and reload wait_cnt.
- Latency: with WAIT_CYCLES=N, pready_o rises in access cycle N+1. A transfer takes N+2 cycles including setup.
- Back-to-back transfers: the cycle after completion is IDLE. A setup phase presented there is accepted with no bubble.
- Address decode, using the latched address a:
  - a < DEPTH: memory word.
  - a == 8'hFF: read returns {16'h0, xfer_cnt_o}; a write is an error.
  - Any other a: error.
- Read completion (pready_o=1, no error): prdata_o = mem[a]. Otherwise prdata_o=0, including all non-completion cycles.
- Write completion (no error): mem[a] <= latched pwdata at the completion edge.
- Error completion:
  - pslverr_o=1 together with pready_o=1.
  - Memory is unchanged and prdata_o=0.
  - The transfer is still counted.
- Protocol violation: penable_i=1 with psel_i=1 while in IDLE (no setup seen). Respond in the same cycle with pready_o=1 and pslverr_o=1. No access is performed, xfer_cnt increments, state stays IDLE.
- psel_i=0 in IDLE: all outputs 0.
- xfer_cnt_o: increments by 1 on every completion edge; wraps from 16'hFFFF to 0.
- Side load:
  - On an edge with ld_en_i=1 and ld_addr_i < DEPTH: mem[ld_addr_i] <= ld_data_i.
  - ld_addr_i >= DEPTH is ignored silently.
  - Side load is independent of the FSM.
  - If an APB write commits to the same address on the same edge, the APB write wins.
- A read that completes on the same edge as a side load to its address returns the old (pre-edge) value.

Test Plan:
- Reset, WAIT_CYCLES=1: side-load mem[0]=32'h0000_0005 and mem[1]=32'h0000_0007. APB read addr 0 -> pready_o high in the 2nd access cycle, prdata_o=5, pslverr_o=0. Read addr 1 back-to-back -> prdata_o=7; xfer_cnt_o=2.
- APB write addr 3 data 32'hDEAD_BEEF, then read addr 3 -> prdata_o=32'hDEAD_BEEF; both complete with pslverr_o=0.
- Read addr 8'h20 (DEPTH=16) -> pready_o=1, pslverr_o=1, prdata_o=0. Write 8'hFF -> pslverr_o=1. Read 8'hFF -> prdata_o=count of prior transfers, pslverr_o=0.
- Same-edge collision: APB write addr 2 = 32'h1111_1111 and side load addr 2 = 32'h2222_2222 commit together -> subsequent read returns 32'h1111_1111.
- Abort: setup for read addr 0, then psel_i=0 during wait -> no pready_o, xfer_cnt_o unchanged. Separately, penable_i without setup -> immediate pready_o=1 with pslverr_o=1.
- Assert presetn_i low mid-wait during a write to addr 4 -> outputs drop to 0 asynchronously. After release, read addr 4 -> 0 and xfer_cnt_o=1 (only the post-reset read).

Source files
------------

// File: rtl/apb_mem_responder.sv
// APB completer with a small word memory, wait states and error reporting.
// Also exposes a read-only transfer counter and a side-load write port.
module apb_mem_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [7:0]  paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  input  logic        ld_en_i,
  input  logic [7:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic [15:0] xfer_cnt_o
);

  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wait;
  logic [15:0] r_cnt;
  logic [31:0] r_mem [DEPTH];

  logic        w_setup;
  logic        w_done;
  logic        w_viol;
  logic        w_dec;
  logic        w_in_mem;
  logic        w_is_cnt;
  logic        w_err;
  logic        w_commit;
  logic        w_fin;
  logic [31:0] w_rword;

  // State register
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next state and phase strobes
  always_comb begin
    w_next  = r_state;
    w_setup = 1'b0;
    w_done  = 1'b0;
    w_viol  = 1'b0;
    w_dec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          w_setup = 1'b1;
          w_next  = S_ACCESS;
        end else if (psel_i && penable_i) begin
          w_viol = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!psel_i) begin
          w_next = S_IDLE;
        end else if (!penable_i) begin
          w_setup = 1'b1;
        end else if (r_wait != 4'd0) begin
          w_dec = 1'b1;
        end else begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_in_mem = r_addr < DEPTH8;
  assign w_is_cnt = r_addr == 8'hFF;
  assign w_err    = !w_in_mem && !(w_is_cnt && !r_write);
  assign w_commit = w_done && r_write && !w_err;
  // Reset is folded in so outputs drop the instant reset asserts
  assign w_fin    = presetn_i && (w_done || w_viol);

  // Read mux over memory words and the counter register
  always_comb begin
    w_rword = w_is_cnt ? {16'h0, r_cnt} : 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_addr == 8'(i)) w_rword = r_mem[i];
    end
  end

  assign pready_o   = w_fin;
  assign pslverr_o  = presetn_i && (w_viol || (w_done && w_err));
  assign prdata_o   = (presetn_i && w_done && !r_write && !w_err)
                    ? w_rword : 32'h0;
  assign xfer_cnt_o = r_cnt;

  // Latch the request at setup and run the wait-state counter
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_addr  <= 8'h0;
      r_write <= 1'b0;
      r_wdata <= 32'h0;
      r_wait  <= 4'd0;
    end else if (w_setup) begin
      r_addr  <= paddr_i;
      r_write <= pwrite_i;
      r_wdata <= pwdata_i;
      r_wait  <= 4'(WAIT_CYCLES);
    end else if (w_dec) begin
      r_wait <= r_wait - 4'd1;
    end
  end

  // Count every completed transfer, errored ones included
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i)  r_cnt <= 16'h0;
    else if (w_fin)  r_cnt <= r_cnt + 16'd1;
  end

  // Memory: side load first so a same-edge APB write overrides it
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_en_i && ld_addr_i == 8'(i)) r_mem[i] <= ld_data_i;
        if (w_commit && r_addr == 8'(i))   r_mem[i] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Bench for apb_mem_responder: vector table, corner sequences and
// randomized transfers scored against a transfer-level memory model.
module tb_apb_mem_responder;

  localparam int DEPTH = 16;
  localparam int WAITS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [7:0]  paddr = 8'h0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h0;
  logic [31:0] ld_data = 32'h0;
  logic [15:0] xfer_cnt;

  apb_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .pclk_i(clk), .presetn_i(rst_n),
    .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .xfer_cnt_o(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  logic [15:0] m_cnt;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_cnt = 16'h0;
  endtask

  function automatic bit exp_err_f(input bit wr, input logic [7:0] a);
    return !((a < 8'(DEPTH)) || (a == 8'hFF && !wr));
  endfunction

  function automatic logic [31:0] exp_rd_f(input bit wr,
                                           input logic [7:0] a);
    if (wr || exp_err_f(wr, a)) return 32'h0;
    if (a == 8'hFF) return {16'h0, m_cnt};
    return m_mem[a[3:0]];
  endfunction

  // Side-load one word over a single edge
  task automatic sload(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk) #1;
    ld_en = 1'b0;
    if (a < 8'(DEPTH)) m_mem[a[3:0]] = d;
  endtask

  // Full APB transfer; optional side load lands on the completion edge
  task automatic xfer(input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input bit ld,
                      input logic [7:0] la, input logic [31:0] ldd,
                      output logic [31:0] rd, output bit er,
                      output int lat);
    bit done = 0;
    bit e;
    psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = d;
    @(posedge clk) #1;
    penable = 1'b1;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      lat++;
      if (pready) begin
        done = 1;
        rd = prdata;
        er = pslverr;
        if (ld) begin
          ld_en = 1'b1; ld_addr = la; ld_data = ldd;
        end
      end else begin
        @(posedge clk) #1;
      end
    end
    if (!done) chk("timeout_pready", 32'h0, 32'h1);
    e = exp_err_f(wr, a);
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0; ld_en = 1'b0;
    if (ld && la < 8'(DEPTH)) m_mem[la[3:0]] = ldd;
    if (done) begin
      if (wr && !e) m_mem[a[3:0]] = d;
      m_cnt++;
    end
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;
  logic [31:0] erd;
  bit          eer;
  logic [15:0] cnt0;

  initial begin
    vecs[0] = '{0, 8'h00, 32'h0,         32'h5,         0};
    vecs[1] = '{0, 8'h01, 32'h0,         32'h7,         0};
    vecs[2] = '{1, 8'h03, 32'hDEAD_BEEF, 32'h0,         0};
    vecs[3] = '{0, 8'h03, 32'h0,         32'hDEAD_BEEF, 0};
    vecs[4] = '{0, 8'h20, 32'h0,         32'h0,         1};
    vecs[5] = '{1, 8'hFF, 32'h123,       32'h0,         1};
    vecs[6] = '{0, 8'hFF, 32'h0,         32'h6,         0};
    vecs[7] = '{0, 8'h0F, 32'h0,         32'h0,         0};
    vecs[8] = '{0, 8'h10, 32'h0,         32'h0,         1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pready", {31'h0, pready}, 32'h0);
    chk("reset_pslverr", {31'h0, pslverr}, 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_cnt", {16'h0, xfer_cnt}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    sload(8'h00, 32'h5);
    sload(8'h01, 32'h7);
    sload(8'h10, 32'hBAD0_BAD0);
    chk("idle_pready", {31'h0, pready}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, 0, 8'h0, 32'h0,
           rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, er},
          {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, WAITS + 1);
      chk($sformatf("vec%0d_cnt", i), {16'h0, xfer_cnt}, i + 1);
    end

    xfer(1, 8'h02, 32'h1111_1111, 1, 8'h02, 32'h2222_2222, rd, er, lat);
    xfer(0, 8'h02, 32'h0, 0, 8'h0, 32'h0, rd, er, lat);
    chk("collision_apb_wins", rd, 32'h1111_1111);

    xfer(0, 8'h01, 32'h0, 1, 8'h01, 32'h3333_3333, rd, er, lat);
    chk("read_old_on_load", rd, 32'h7);
    xfer(0, 8'h01, 32'h0, 0, 8'h0, 32'h0, rd, er, lat);
    chk("read_new_after_load", rd, 32'h3333_3333);

    cnt0 = xfer_cnt;
    psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0;
    @(posedge clk) #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_wait_pready", {31'h0, pready}, 32'h0);
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready", {31'h0, pready}, 32'h0);
    @(posedge clk) #1;
    chk("abort_cnt", {16'h0, xfer_cnt}, {16'h0, cnt0});

    psel = 1'b1; penable = 1'b1; paddr = 8'h00; pwrite = 1'b0;
    @(negedge clk);
    chk("viol_pready", {31'h0, pready}, 32'h1);
    chk("viol_pslverr", {31'h0, pslverr}, 32'h1);
    chk("viol_prdata", prdata, 32'h0);
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
    m_cnt++;
    chk("viol_cnt", {16'h0, xfer_cnt}, {16'h0, m_cnt});

    for (int t = 0; t < 60; t++) begin
      logic [7:0]  a;
      logic [7:0]  la;
      logic [31:0] d;
      logic [31:0] ldd;
      bit          wr;
      bit          ld;
      case ($urandom_range(0, 3))
        0: a = 8'hFF;
        1: a = 8'($urandom_range(0, 255));
        default: a = 8'($urandom_range(0, DEPTH - 1));
      endcase
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      ld  = ($urandom_range(0, 3) == 0);
      la  = ($urandom_range(0, 1) == 1) ? a
            : 8'($urandom_range(0, DEPTH + 3));
      ldd = $urandom;
      erd = exp_rd_f(wr, a);
      eer = exp_err_f(wr, a);
      xfer(wr, a, d, ld, la, ldd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata a=%h w=%0d", t, a, wr), rd, erd);
      chk($sformatf("rnd%0d_err", t), {31'h0, er}, {31'h0, eer});
      chk($sformatf("rnd%0d_cnt", t), {16'h0, xfer_cnt},
          {16'h0, m_cnt});
    end

    psel = 1'b1; penable = 1'b0; paddr = 8'h04;
    pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(posedge clk) #1;
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pready", {31'h0, pready}, 32'h0);
    chk("arst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("arst_prdata", prdata, 32'h0);
    chk("arst_cnt", {16'h0, xfer_cnt}, 32'h0);
    model_reset();
    psel = 1'b0; penable = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
    xfer(0, 8'h04, 32'h0, 0, 8'h0, 32'h0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'h0);
    chk("post_rst_err", {31'h0, er}, 32'h0);
    chk("post_rst_cnt", {16'h0, xfer_cnt}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
